// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion engine.
package sprite_pkg;

  // Facing code driven on sel[3:2] of each channel.
  typedef enum logic [1:0] {
    DOWN  = 2'b00,
    UP    = 2'b01,
    LEFT  = 2'b10,
    RIGHT = 2'b11
  } facing_e;

  // Frame update sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    UPDATE = 2'b01,
    COMMIT = 2'b10
  } state_e;

  // HID usage codes for the movement keys.
  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;

  // A key is held when either of the two reported key bytes carries its code.
  function automatic logic key_down(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

endpackage

// File: rtl/sprite_axis_step.sv
// One-axis motion step: applies a signed velocity to a position, clamps the
// result into [0, limit] and reflects the velocity when the clamp engages.
module sprite_axis_step #(
  parameter int COORD_W = 10
) (
  input  logic [COORD_W-1:0]        pos,
  input  logic signed [COORD_W+1:0] vel,
  input  logic [COORD_W-1:0]        limit,
  output logic [COORD_W-1:0]        next_pos,
  output logic signed [COORD_W+1:0] next_vel,
  output logic                      moved
);

  // Two extra bits keep both underflow below 0 and overflow past the limit visible.
  logic signed [COORD_W+1:0] sum;

  // Next position with clamp-and-bounce; a zero velocity is the only "no move".
  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum      = $signed({2'b00, pos}) + vel;
    next_pos = sum[COORD_W-1:0];
    next_vel = vel;
    moved    = (vel != '0);
    if (sum[COORD_W+1]) begin
      next_pos = '0;
      next_vel = -vel;
    end else if (sum > $signed({2'b00, limit})) begin
      next_pos = limit;
      next_vel = -vel;
    end
  end

endmodule

// File: rtl/sprite_motion_engine.sv
// Frame-synchronous motion and animation engine for N sprites. Each vsync
// falling edge walks all channels through one shared pair of axis steppers,
// then commits positions and selects together so they never disagree.
module sprite_motion_engine
  import sprite_pkg::*;
#(
  parameter int N_SPRITES   = 4,
  parameter int COORD_W     = 10,
  parameter int X_MAX       = 639,
  parameter int Y_MAX       = 479,
  parameter int SPRITE_SIZE = 16,
  parameter int STEP        = 2,
  parameter int ANIM_DIV    = 8
) (
  input  logic                           Clk,
  input  logic                           Reset_n,
  input  logic                           vs,
  input  logic [15:0]                    keycode,
  input  logic                           enable,
  output logic [N_SPRITES*COORD_W-1:0]   sprite_x,
  output logic [N_SPRITES*COORD_W-1:0]   sprite_y,
  output logic [N_SPRITES*4-1:0]         sel,
  output logic                           frame_done,
  output logic                           busy,
  output logic                           overrun
);

  localparam int CH_W  = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;
  localparam int CNT_W = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int VEL_W = COORD_W + 2;

  localparam logic [CH_W-1:0]          LAST_CH = CH_W'(N_SPRITES - 1);
  localparam logic [COORD_W-1:0]       X_LIM   = COORD_W'(X_MAX - SPRITE_SIZE + 1);
  localparam logic [COORD_W-1:0]       Y_LIM   = COORD_W'(Y_MAX - SPRITE_SIZE + 1);
  localparam logic signed [VEL_W-1:0]  V_POS   = VEL_W'(STEP);
  localparam logic signed [VEL_W-1:0]  V_NEG   = -V_POS;
  localparam logic [CNT_W-1:0]         CNT_TOP = CNT_W'(ANIM_DIV - 1);

  // Keyboard sprite starts roughly centred on the 640x480 screen.
  localparam int CH0_X = 312;
  localparam int CH0_Y = 232;

  // vsync synchroniser and edge detector
  logic vs_meta, vs_sync, vs_prev, tick;

  // sequencer
  state_e          state;
  logic [CH_W-1:0] ch;

  // committed per-channel state (drives the outputs)
  logic [COORD_W-1:0] pos_x [N_SPRITES];
  logic [COORD_W-1:0] pos_y [N_SPRITES];
  facing_e            face  [N_SPRITES];
  logic [1:0]         anim  [N_SPRITES];

  // internal per-channel state, not visible outside
  logic [CNT_W-1:0]   anim_cnt [N_SPRITES];
  logic               vx_neg   [N_SPRITES];
  logic               vy_neg   [N_SPRITES];

  // shadow copy built up during UPDATE
  logic [COORD_W-1:0] sh_x    [N_SPRITES];
  logic [COORD_W-1:0] sh_y    [N_SPRITES];
  facing_e            sh_face [N_SPRITES];
  logic [1:0]         sh_anim [N_SPRITES];

  // current-channel datapath
  logic [COORD_W-1:0]       cur_x, cur_y, nxt_x, nxt_y;
  logic signed [VEL_W-1:0]  cur_vx, cur_vy, nxt_vx, nxt_vy;
  logic signed [VEL_W-1:0]  key_vx, key_vy;
  logic                     key_w, key_a, key_s, key_d;
  logic                     x_moved, y_moved;
  facing_e                  cur_face, nxt_face;
  logic [1:0]               cur_anim, nxt_anim;
  logic [CNT_W-1:0]         cur_cnt, nxt_cnt;

  // Bring vs into the Clk domain and flag its 1->0 transition for one cycle.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values and the chain behaves as real flops.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      vs_meta <= 1'b1;
      vs_sync <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      vs_meta <= vs;
      vs_sync <= vs_meta;
      vs_prev <= vs_sync;
    end
  end

  assign tick = vs_prev & ~vs_sync;

  // Select the channel under update and derive its velocity for this frame.
  always_comb begin
    cur_x    = pos_x[ch];
    cur_y    = pos_y[ch];
    cur_face = face[ch];
    cur_anim = anim[ch];
    cur_cnt  = anim_cnt[ch];

    key_w = key_down(keycode, KEY_W);
    key_a = key_down(keycode, KEY_A);
    key_s = key_down(keycode, KEY_S);
    key_d = key_down(keycode, KEY_D);

    // Opposing keys cancel on their axis; the two axes are independent.
    key_vx = '0;
    if (key_d && !key_a)      key_vx = V_POS;
    else if (key_a && !key_d) key_vx = V_NEG;
    key_vy = '0;
    if (key_s && !key_w)      key_vy = V_POS;
    else if (key_w && !key_s) key_vy = V_NEG;

    if (ch == '0) begin
      cur_vx = key_vx;
      cur_vy = key_vy;
    end else begin
      cur_vx = vx_neg[ch] ? V_NEG : V_POS;
      cur_vy = vy_neg[ch] ? V_NEG : V_POS;
    end
  end

  sprite_axis_step #(.COORD_W(COORD_W)) u_step_x (
    .pos      (cur_x),
    .vel      (cur_vx),
    .limit    (X_LIM),
    .next_pos (nxt_x),
    .next_vel (nxt_vx),
    .moved    (x_moved)
  );

  sprite_axis_step #(.COORD_W(COORD_W)) u_step_y (
    .pos      (cur_y),
    .vel      (cur_vy),
    .limit    (Y_LIM),
    .next_pos (nxt_y),
    .next_vel (nxt_vy),
    .moved    (y_moved)
  );

  // Facing and animation follow the velocity applied this frame, before any bounce.
  always_comb begin
    nxt_face = cur_face;
    if (x_moved)      nxt_face = cur_vx[VEL_W-1] ? LEFT : RIGHT;
    else if (y_moved) nxt_face = cur_vy[VEL_W-1] ? UP : DOWN;

    nxt_anim = cur_anim;
    nxt_cnt  = cur_cnt;
    if (!(x_moved || y_moved)) begin
      nxt_cnt  = '0;
      nxt_anim = '0;
    end else if (cur_cnt == CNT_TOP) begin
      nxt_cnt  = '0;
      nxt_anim = cur_anim + 2'd1;
    end else begin
      nxt_cnt = cur_cnt + CNT_W'(1);
    end
  end

  // Capture each channel's result as the iterator walks past it.
  // NOTE: the shadow needs no reset; every entry is rewritten during UPDATE before COMMIT reads it.
  always_ff @(posedge Clk) begin
    if (state == UPDATE) begin
      sh_x[ch]    <= nxt_x;
      sh_y[ch]    <= nxt_y;
      sh_face[ch] <= nxt_face;
      sh_anim[ch] <= nxt_anim;
    end
  end

  // Sequencer: IDLE waits for a tick, UPDATE walks the channels, COMMIT holds
  // the frame_done pulse. The shadow is copied out on the edge that enters
  // COMMIT, so new positions and frame_done become visible in the same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      ch         <= '0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        pos_x[i]    <= (i == 0) ? COORD_W'(CH0_X) : COORD_W'(i * 64);
        pos_y[i]    <= (i == 0) ? COORD_W'(CH0_Y) : COORD_W'(i * 48);
        face[i]     <= DOWN;
        anim[i]     <= '0;
        anim_cnt[i] <= '0;
        vx_neg[i]   <= (i % 2 == 0);
        vy_neg[i]   <= 1'b0;
      end
    end else begin
      frame_done <= 1'b0;
      if (tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (tick && enable) begin
            state <= UPDATE;
            ch    <= '0;
            busy  <= 1'b1;
          end
        end

        UPDATE: begin
          anim_cnt[ch] <= nxt_cnt;
          if (ch != '0) begin
            vx_neg[ch] <= nxt_vx[VEL_W-1];
            vy_neg[ch] <= nxt_vy[VEL_W-1];
          end
          if (ch == LAST_CH) begin
            for (int i = 0; i < N_SPRITES; i++) begin
              pos_x[i] <= sh_x[i];
              pos_y[i] <= sh_y[i];
              face[i]  <= sh_face[i];
              anim[i]  <= sh_anim[i];
            end
            // The last channel is still on the datapath; take it directly.
            pos_x[LAST_CH] <= nxt_x;
            pos_y[LAST_CH] <= nxt_y;
            face[LAST_CH]  <= nxt_face;
            anim[LAST_CH]  <= nxt_anim;
            frame_done     <= 1'b1;
            state          <= COMMIT;
          end else begin
            ch <= ch + CH_W'(1);
          end
        end

        COMMIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Pack the committed per-channel registers onto the output buses.
  for (genvar g = 0; g < N_SPRITES; g++) begin : g_pack
    assign sprite_x[g*COORD_W +: COORD_W] = pos_x[g];
    assign sprite_y[g*COORD_W +: COORD_W] = pos_y[g];
    assign sel[g*4 +: 4]                  = {face[g], anim[g]};
  end

endmodule

// File: tb/tb_sprite_motion_engine.sv
// Self-checking bench for sprite_motion_engine against an integer-level
// model of the motion, bounce, facing and animation rules.
module tb_sprite_motion_engine;

  localparam int N    = 4;
  localparam int CW   = 10;
  localparam int XM   = 639;
  localparam int YM   = 479;
  localparam int SZ   = 16;
  localparam int STEP = 2;
  localparam int DIV  = 8;
  localparam int XL   = XM - SZ + 1;
  localparam int YL   = YM - SZ + 1;

  logic          Clk     = 1'b0;
  logic          Reset_n = 1'b0;
  logic          vs      = 1'b1;
  logic          enable  = 1'b1;
  logic [15:0]   keycode = 16'h0000;
  logic [N*CW-1:0] sprite_x, sprite_y;
  logic [N*4-1:0]  sel;
  logic          frame_done, busy, overrun;

  int errors = 0;
  int checks = 0;

  // model state: plain integers, facing as 0..3, anim as 0..3
  int mx[N], my[N], mvx[N], mvy[N], mface[N], manim[N], mcnt[N];

  sprite_motion_engine #(
    .N_SPRITES(N), .COORD_W(CW), .X_MAX(XM), .Y_MAX(YM),
    .SPRITE_SIZE(SZ), .STEP(STEP), .ANIM_DIV(DIV)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .vs(vs), .keycode(keycode), .enable(enable),
    .sprite_x(sprite_x), .sprite_y(sprite_y), .sel(sel),
    .frame_done(frame_done), .busy(busy), .overrun(overrun)
  );

  always #10 Clk = ~Clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i]    = (i == 0) ? 312 : i * 64;
      my[i]    = (i == 0) ? 232 : i * 48;
      mvx[i]   = (i % 2 == 1) ? STEP : -STEP;
      mvy[i]   = STEP;
      mface[i] = 0;
      manim[i] = 0;
      mcnt[i]  = 0;
    end
  endfunction

  function automatic void model_anim(input int i, input bit moving);
    if (!moving) begin
      mcnt[i]  = 0;
      manim[i] = 0;
    end else begin
      mcnt[i] = mcnt[i] + 1;
      if (mcnt[i] == DIV) begin
        mcnt[i]  = 0;
        manim[i] = (manim[i] + 1) % 4;
      end
    end
  endfunction

  function automatic bit held(input logic [15:0] kc, input logic [7:0] code);
    return (kc[7:0] == code) || (kc[15:8] == code);
  endfunction

  function automatic void model_frame(input logic [15:0] kc);
    int dx, dy, nx, ny;
    dx = (held(kc, 8'h07) ? STEP : 0) - (held(kc, 8'h04) ? STEP : 0);
    dy = (held(kc, 8'h16) ? STEP : 0) - (held(kc, 8'h1A) ? STEP : 0);
    nx = mx[0] + dx;
    ny = my[0] + dy;
    mx[0] = (nx < 0) ? 0 : (nx > XL) ? XL : nx;
    my[0] = (ny < 0) ? 0 : (ny > YL) ? YL : ny;
    if (dx != 0)      mface[0] = (dx > 0) ? 3 : 2;
    else if (dy != 0) mface[0] = (dy < 0) ? 1 : 0;
    model_anim(0, (dx != 0) || (dy != 0));
    for (int i = 1; i < N; i++) begin
      mface[i] = (mvx[i] > 0) ? 3 : 2;
      nx = mx[i] + mvx[i];
      ny = my[i] + mvy[i];
      if (nx < 0)       begin nx = 0;  mvx[i] = -mvx[i]; end
      else if (nx > XL) begin nx = XL; mvx[i] = -mvx[i]; end
      if (ny < 0)       begin ny = 0;  mvy[i] = -mvy[i]; end
      else if (ny > YL) begin ny = YL; mvy[i] = -mvy[i]; end
      mx[i] = nx;
      my[i] = ny;
      model_anim(i, 1'b1);
    end
  endfunction

  // Compare the three packed output buses with the model.
  task automatic score(input string tag);
    logic [N*CW-1:0] ex, ey;
    logic [N*4-1:0]  es;
    for (int i = 0; i < N; i++) begin
      ex[i*CW +: CW] = mx[i][CW-1:0];
      ey[i*CW +: CW] = my[i][CW-1:0];
      es[i*4 +: 4]   = {mface[i][1:0], manim[i][1:0]};
    end
    checks++;
    if (sprite_x !== ex) begin
      errors++;
      $display("FAIL %s sprite_x: got %h expected %h", tag, sprite_x, ex);
    end
    checks++;
    if (sprite_y !== ey) begin
      errors++;
      $display("FAIL %s sprite_y: got %h expected %h", tag, sprite_y, ey);
    end
    checks++;
    if (sel !== es) begin
      errors++;
      $display("FAIL %s sel: got %h expected %h", tag, sel, es);
    end
  endtask

  // Drop vs, wait (bounded) for frame_done, then raise vs and let it settle.
  // lat counts rising edges from the vs fall to the frame_done sample.
  task automatic run_frame(output int lat, output bit ok, output logic busy_at_done);
    lat = 0;
    ok = 1'b0;
    busy_at_done = 1'b0;
    @(negedge Clk);
    vs = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge Clk);
      if (frame_done === 1'b1) begin
        lat = c;
        ok = 1'b1;
        busy_at_done = busy;
        break;
      end
    end
    vs = 1'b1;
    repeat (4) @(negedge Clk);
  endtask

  task automatic frame_step(input string tag);
    int lat;
    bit ok;
    logic b;
    run_frame(lat, ok, b);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s frame_done: not seen within 40 cycles", tag);
    end else begin
      model_frame(keycode);
    end
    score(tag);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    model_reset();
    repeat (3) @(negedge Clk);
    score("reset_hold");
    checks++;
    if ({frame_done, busy, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000", {frame_done, busy, overrun});
    end
    Reset_n = 1'b1;
    repeat (4) @(negedge Clk);
    score("reset_release");
  endtask

  task automatic test_first_frame();
    int lat;
    bit ok;
    logic b;
    keycode = 16'h0000;
    run_frame(lat, ok, b);
    checks++;
    if (!ok || lat != N + 3) begin
      errors++;
      $display("FAIL first_latency: got %0d edges expected %0d (seen=%0d)", lat, N + 3, ok);
    end
    checks++;
    if (b !== 1'b1) begin
      errors++;
      $display("FAIL first_busy_at_done: got %b expected 1", b);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL first_busy_after: got %b expected 0", busy);
    end
    model_frame(keycode);
    score("first_frame");
    checks++;
    if (sprite_x[CW-1:0] !== 10'd312 || sprite_y[CW-1:0] !== 10'd232 || sel[3:0] !== 4'b0000) begin
      errors++;
      $display("FAIL first_ch0: got x=%0d y=%0d sel=%b expected 312 232 0000",
               sprite_x[CW-1:0], sprite_y[CW-1:0], sel[3:0]);
    end
    checks++;
    if (sprite_x[CW +: CW] !== 10'd66 || sprite_y[CW +: CW] !== 10'd50) begin
      errors++;
      $display("FAIL first_ch1: got (%0d,%0d) expected (66,50)", sprite_x[CW +: CW], sprite_y[CW +: CW]);
    end
  endtask

  task automatic test_walk();
    keycode = 16'h0007;
    for (int f = 0; f < 8; f++) frame_step("walk_right");
    checks++;
    if (sprite_x[CW-1:0] !== 10'd328 || sel[3:0] !== 4'b1101) begin
      errors++;
      $display("FAIL walk_right_end: got x=%0d sel=%b expected 328 1101", sprite_x[CW-1:0], sel[3:0]);
    end
    keycode = 16'h1A04;
    for (int f = 0; f < 3; f++) frame_step("walk_diag");
    checks++;
    if (sprite_x[CW-1:0] !== 10'd322 || sprite_y[CW-1:0] !== 10'd226 || sel[3:2] !== 2'b10) begin
      errors++;
      $display("FAIL walk_diag_end: got x=%0d y=%0d face=%b expected 322 226 10",
               sprite_x[CW-1:0], sprite_y[CW-1:0], sel[3:2]);
    end
  endtask

  task automatic test_left_clamp();
    int extra;
    extra = 0;
    keycode = 16'h0004;
    for (int f = 0; f < 200 && extra < 3; f++) begin
      if (mx[0] == 0) extra++;
      frame_step("left_clamp");
    end
    checks++;
    if (sprite_x[CW-1:0] !== 10'd0 || sel[3:2] !== 2'b10) begin
      errors++;
      $display("FAIL left_clamp_end: got x=%0d face=%b expected 0 10", sprite_x[CW-1:0], sel[3:2]);
    end
  endtask

  task automatic test_bounce();
    bit bounced;
    bounced = 1'b0;
    keycode = 16'h0000;
    for (int f = 0; f < 200 && !bounced; f++) begin
      frame_step("bounce_run");
      if (mx[1] == XL && mvx[1] < 0) bounced = 1'b1;
    end
    checks++;
    if (!bounced) begin
      errors++;
      $display("FAIL bounce_reach: ch1 never reached the right edge within 200 frames");
    end else begin
      checks++;
      if (sprite_x[CW +: CW] !== 10'd624 || sel[7:6] !== 2'b11) begin
        errors++;
        $display("FAIL bounce_edge: got x=%0d face=%b expected 624 11", sprite_x[CW +: CW], sel[7:6]);
      end
      frame_step("bounce_after");
      checks++;
      if (sprite_x[CW +: CW] !== 10'd622 || sel[7:6] !== 2'b10) begin
        errors++;
        $display("FAIL bounce_back: got x=%0d face=%b expected 622 10", sprite_x[CW +: CW], sel[7:6]);
      end
    end
  endtask

  function automatic logic [7:0] rand_key();
    case ($urandom_range(0, 5))
      0: return 8'h04;
      1: return 8'h07;
      2: return 8'h16;
      3: return 8'h1A;
      4: return 8'h00;
      default: return 8'($urandom);
    endcase
  endfunction

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      keycode = {rand_key(), rand_key()};
      frame_step("random");
    end
  endtask

  task automatic test_overrun();
    int dones;
    dones = 0;
    keycode = 16'h0016;
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b expected 0", overrun);
    end
    @(negedge Clk) vs = 1'b0;
    @(negedge Clk) vs = 1'b1;
    @(negedge Clk) vs = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge Clk);
      if (frame_done === 1'b1) dones++;
    end
    vs = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL overrun_dones: got %0d frame_done pulses expected 1", dones);
    end
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_set: got %b expected 1", overrun);
    end
    model_frame(keycode);
    score("overrun_frame");
    frame_step("overrun_next");
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b expected 1", overrun);
    end
  endtask

  task automatic test_pause();
    int dones, busies;
    dones = 0;
    busies = 0;
    enable = 1'b0;
    keycode = 16'h0007;
    @(negedge Clk) vs = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge Clk);
      if (frame_done === 1'b1) dones++;
      if (busy === 1'b1) busies++;
    end
    vs = 1'b1;
    repeat (4) @(negedge Clk);
    checks++;
    if (dones != 0 || busies != 0) begin
      errors++;
      $display("FAIL pause_idle: got %0d frame_done and %0d busy cycles expected 0 and 0", dones, busies);
    end
    score("pause");
    enable = 1'b1;
  endtask

  task automatic test_reset_mid_update();
    bit seen;
    seen = 1'b0;
    keycode = 16'h0007;
    @(negedge Clk) vs = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge Clk);
      if (busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL midreset_busy: update never started within 10 cycles");
    end
    #3;
    Reset_n = 1'b0;
    #1;
    model_reset();
    score("midreset");
    checks++;
    if ({frame_done, busy, overrun} !== 3'b000) begin
      errors++;
      $display("FAIL midreset_flags: got %b expected 000", {frame_done, busy, overrun});
    end
    vs = 1'b1;
    repeat (3) @(negedge Clk);
    Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    keycode = 16'h0000;
    frame_step("post_reset");
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_walk();
    test_left_clamp();
    test_bounce();
    test_random();
    test_overrun();
    test_pause();
    test_reset_mid_update();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
